trace_sink: RTL
===============

Name: trace_sink

Overview:
- Consumer end of the Gouram trace port.
- Accepts completed trace records from the trace unit, buffers them in a FIFO, and serialises each record into framed 32-bit words on a ready/valid stream for off-chip readout (UART/DMA bridge).
- Tracks dropped records and the trace unit's lock indication.
- Emits a terminator frame once the trace unit locks and the buffer has drained.

Parameters:
- TRACE_W, 96, packed width of one trace record; the top level sets it to $bits(trace_format).
- DEPTH, 8, FIFO depth in records; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- trace_i  in  TRACE_W  trace record (trace_format, packed)
- trace_valid_i  in  1  trace_i holds a new record this cycle (single-cycle strobe)
- capture_enable_i  in  1  trace unit capture enable
- lock_i  in  1  trace unit lock; sticky at source
- out_data_o  out  32  stream word
- out_valid_o  out  1  out_data_o is valid
- out_ready_i  in  1  downstream accepts word
- out_last_o  out  1  final word of the current frame
- fifo_level_o  out  $clog2(DEPTH)+1  records currently buffered
- overflow_o  out  1  sticky: at least one record was dropped
- done_o  out  1  terminator frame sent; block idle until reset

Behaviour:
- Reset is synchronous and active-low on clk. All outputs reset to 0; FIFO empty; seq=0; drop_cnt=0; lock_seen=0; state=IDLE.
- WORDS = ceil(TRACE_W/32). Frame = 1 header word + WORDS payload words, least-significant word first. The final payload word is zero-padded above bit TRACE_W.
- Data header: {8'hC7, seq[7:0], drop_cnt[7:0], WORDS[7:0]}.
- Terminator header: {8'hE0, seq, drop_cnt, 8'h00}, with out_last_o=1.
- Accept condition: trace_valid_i && capture_enable_i && !lock_i && !lock_seen.
  - Accept with FIFO not full: push.
  - Accept with FIFO full (evaluated at the start of the cycle, before any same-cycle pop): drop. drop_cnt increments, saturating at 255; overflow_o is set.
  - trace_valid_i with capture_enable_i=0 or locked: ignored, not counted as a drop.
- lock_seen is set on the first cycle lock_i=1 and cleared only by reset.
- Stream rule: once out_valid_o is asserted, out_data_o and out_last_o hold stable until out_ready_i. A word transfers on out_valid_o && out_ready_i.
- FSM states:
  - IDLE:
    - FIFO non-empty -> HDR.
    - FIFO empty and lock_seen -> TERM.
  - HDR: drives the data header from the FIFO head.
    - On transfer: seq += 1 (wraps at 8 bits) and word_idx = 0 -> PAYLOAD.
    - drop_cnt on that cycle becomes 1 if a drop occurs in the same cycle, else 0.
  - PAYLOAD: drives trace[32*word_idx +: 32].
    - On transfer, word_idx increments.
    - At word_idx = WORDS-1: out_last_o=1. On transfer, pop the FIFO, then go to HDR if more records remain, else IDLE. No bubble is required between frames.
  - TERM: drives the terminator header. On transfer -> DONE and done_o=1.
  - DONE: out_valid_o=0. Stays here until reset.
- Lock arriving mid-frame: the current frame and all buffered records complete before TERM.
- fifo_level_o is updated the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- Latency: a record pushed into an empty FIFO at cycle N presents its header at N+1, assuming out_ready_i is held high.
- Reset mid-frame: the frame is abandoned; no partial-frame recovery.

Decomposition:
- gouram_datatypes gains:
  - sink_state_t enum (IDLE, HDR, PAYLOAD, TERM, DONE)
  - SYNC_DATA=8'hC7
  - SYNC_TERM=8'hE0
- Sub-module trace_fifo #(WIDTH, DEPTH):
  - synchronous, first-word-fall-through
  - ports: push, pop, din, dout, full, empty, level
  - reset synchronous active-low

Test Plan:
- Single record, TRACE_W=96: push 96'h33333333_22222222_11111111 with out_ready_i=1 -> words C7000003, 11111111, 22222222, 33333333; out_last_o only on the last word; fifo_level_o returns to 0.
- Backpressure: hold out_ready_i=0 for 5 cycles on payload word 2 -> out_data_o stays 22222222 and out_valid_o stays 1 throughout; the next word follows 1 cycle after ready rises.
- Overflow with DEPTH=4: out_ready_i=0, push 6 records -> fifo_level_o=4 and overflow_o=1. Release ready -> first header is C7000203; the second frame's header is C7010003.
- Lock with 2 records queued: assert lock_i, then pulse trace_valid_i -> the extra record is ignored. Two data frames (seq 0 and 1) are followed by E0020000 with out_last_o=1; then done_o=1 and out_valid_o=0 permanently.
- Capture gating: trace_valid_i with capture_enable_i=0 for 3 cycles -> no push, no drop, overflow_o=0, no stream output.
- Reset mid-frame: drop rst_n after payload word 1 -> next cycle all outputs are 0. A new record afterwards yields header C7000003 (seq restarts at 0).

Source files
------------

// File: rtl/trace_sink_pkg.sv
// Shared types and constants for the trace sink: record layout, FSM states,
// frame sync bytes and the record-to-word sizing helper.
package trace_sink_pkg;

    // One completed trace record as delivered by the trace unit (pc in the low word).
    typedef struct packed {
        logic [31:0] timestamp;
        logic [31:0] instr;
        logic [31:0] pc;
    } trace_format;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        TERM,
        DONE
    } sink_state_t;

    localparam logic [7:0] SYNC_DATA = 8'hC7;
    localparam logic [7:0] SYNC_TERM = 8'hE0;

    // Number of 32-bit stream words needed to carry a record of the given width.
    function automatic int words_for(input int width);
        return (width + 31) / 32;
    endfunction

endpackage

// File: rtl/trace_sink_if.sv
// Ready/valid output stream of the trace sink: 32-bit words with a frame-end marker.
interface trace_sink_if;

    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;

    modport master (
        output out_data_o,
        output out_valid_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o,
        input  out_valid_o,
        input  out_last_o,
        output out_ready_i
    );

endinterface

// File: rtl/trace_sink_fifo.sv
// Synchronous first-word-fall-through FIFO holding whole trace records.
// A push while full is ignored, so the caller decides what counts as a drop.
module trace_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Record storage; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/trace_sink.sv
// Consumer end of the Gouram trace port: buffers completed records and
// serialises each into a framed word stream, then closes with a terminator
// frame once the trace unit has locked and the buffer has drained.
module trace_sink
    import trace_sink_pkg::*;
#(
    parameter int TRACE_W = $bits(trace_format),
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TRACE_W-1:0]       trace_i,
    input  logic                     trace_valid_i,
    input  logic                     capture_enable_i,
    input  logic                     lock_i,
    trace_sink_if.master             out,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic                     done_o
);

    localparam int WORDS = words_for(TRACE_W);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [7:0]       WORDS_B  = 8'(WORDS);

    sink_state_t        state;
    sink_state_t        state_next;
    logic [IDX_W-1:0]   word_idx;
    logic [IDX_W-1:0]   word_idx_next;
    logic [7:0]         seq;
    logic [7:0]         drop_cnt;
    logic               lock_seen;

    logic [TRACE_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;

    logic               accept;
    logic               push;
    logic               drop;
    logic               pop;
    logic               hdr_xfer;

    logic [WORDS*32-1:0] padded;
    logic [31:0]         payload_word;
    logic [31:0]         data_hdr;
    logic [31:0]         term_hdr;

    logic [31:0]         stream_data;
    logic                stream_valid;
    logic                stream_last;

    // Full is judged on the occupancy at the start of the cycle, so a record
    // arriving while full is dropped even if the head is popped this cycle.
    assign accept = trace_valid_i && capture_enable_i && !lock_i && !lock_seen;
    assign push   = accept && !fifo_full;
    assign drop   = accept && fifo_full;

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (trace_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Zero-pad the head record up to a whole number of stream words.
    always_comb begin
        padded                = '0;
        padded[TRACE_W-1:0]   = fifo_dout;
    end

    assign payload_word = padded[32*word_idx +: 32];
    assign data_hdr     = {SYNC_DATA, seq, drop_cnt, WORDS_B};
    assign term_hdr     = {SYNC_TERM, seq, drop_cnt, 8'h00};

    // State, word index, sequence number, drop counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_idx   <= '0;
            seq        <= 8'h00;
            drop_cnt   <= 8'h00;
            lock_seen  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state    <= state_next;
            word_idx <= word_idx_next;
            if (hdr_xfer) begin
                seq      <= seq + 8'd1;
                drop_cnt <= {7'b0, drop};
            end else if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (lock_i) begin
                lock_seen <= 1'b1;
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Frame sequencing; IDLE presents a waiting header at once so a freshly
    // pushed record reaches the stream on the very next cycle.
    always_comb begin
        state_next    = state;
        word_idx_next = word_idx;
        stream_valid  = 1'b0;
        stream_data   = 32'h0;
        stream_last   = 1'b0;
        pop           = 1'b0;
        hdr_xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    stream_valid = 1'b1;
                    stream_data  = data_hdr;
                    if (out.out_ready_i) begin
                        hdr_xfer      = 1'b1;
                        word_idx_next = '0;
                        state_next    = PAYLOAD;
                    end else begin
                        state_next    = HDR;
                    end
                end else if (lock_seen) begin
                    state_next = TERM;
                end
            end
            HDR: begin
                stream_valid = 1'b1;
                stream_data  = data_hdr;
                if (out.out_ready_i) begin
                    hdr_xfer      = 1'b1;
                    word_idx_next = '0;
                    state_next    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                stream_valid = 1'b1;
                stream_data  = payload_word;
                stream_last  = (word_idx == LAST_IDX);
                if (out.out_ready_i) begin
                    if (word_idx == LAST_IDX) begin
                        pop           = 1'b1;
                        word_idx_next = '0;
                        state_next    = (fifo_level > LVL_W'(1)) ? HDR : IDLE;
                    end else begin
                        word_idx_next = word_idx + 1'b1;
                    end
                end
            end
            TERM: begin
                stream_valid = 1'b1;
                stream_data  = term_hdr;
                stream_last  = 1'b1;
                if (out.out_ready_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out.out_data_o  = stream_data;
    assign out.out_valid_o = stream_valid;
    assign out.out_last_o  = stream_last;
    assign fifo_level_o    = fifo_level;
    assign done_o          = (state == DONE);

endmodule
